gate_test_sequencer: RTL and testbench
======================================

GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, meaning wait cycles after each vector is applied before sampling; legal range 0..255.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  run request, sampled only in IDLE.
REQ-006 abort  input  1  synchronous run cancel.
REQ-007 exp_tt  input  4  expected truth table; bit i is the expected output for vector i = {a,b}.
REQ-008 gate_out  input  1  output of the 2-input gate under test.
REQ-009 gate_a  output  1  gate input a, registered.
REQ-010 gate_b  output  1  gate input b, registered.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse at run completion.
REQ-013 pass  output  1  high when the last completed run had no mismatch.
REQ-014 fail_mask  output  4  bit i set if vector i mismatched in the last run.

Function
REQ-015 The FSM SHALL have the states IDLE, SETTLE, SAMPLE and DONE, and an internal 2-bit vec_idx and an 8-bit settle_cnt.
REQ-016 In IDLE, start=1 and abort=0 SHALL latch exp_tt, clear pass and fail_mask, set vec_idx=0, drive {gate_a,gate_b}=2'b00, load settle_cnt=SETTLE_CYCLES, and go to SETTLE.
REQ-017 In SETTLE, the FSM SHALL go to SAMPLE when settle_cnt==0, otherwise decrement settle_cnt; SETTLE lasts SETTLE_CYCLES+1 cycles.
REQ-018 SAMPLE SHALL last one cycle and set fail_mask[vec_idx] when gate_out != latched exp_tt[vec_idx].
REQ-019 From SAMPLE with vec_idx<3, the FSM SHALL increment vec_idx, drive {gate_a,gate_b}=new vec_idx, reload settle_cnt and go to SETTLE.
REQ-020 From SAMPLE with vec_idx==3, the FSM SHALL go to DONE.
REQ-021 Vector order SHALL be 00, 01, 10, 11; the gate inputs SHALL change only on SETTLE entry.
REQ-022 DONE SHALL last one cycle with done=1, set pass=(fail_mask==0) including the final sample, drive gate_a=gate_b=0, and return to IDLE.
REQ-023 Latency: done SHALL be high in the cycle following exactly 4*(SETTLE_CYCLES+2) rising edges after the edge that accepted start.
REQ-024 start outside IDLE SHALL be ignored, and exp_tt changes after acceptance SHALL be ignored.
REQ-025 abort=1 in SETTLE, SAMPLE or DONE SHALL, at the next edge, go to IDLE with done=0, pass=0, fail_mask=0 and gate_a=gate_b=0.
REQ-026 If start and abort are both high in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-027 pass and fail_mask SHALL hold their values in IDLE until the next accepted start or abort.
REQ-028 SETTLE_CYCLES=0 SHALL be legal, giving 2 cycles per vector.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock edge, force IDLE, gate_a=0, gate_b=0, busy=0, done=0, pass=0, fail_mask=0, vec_idx=0 and settle_cnt=0.
REQ-030 Reset asserted mid-run SHALL discard the run with no done pulse.
REQ-031 After rst_n deasserts, the first start SHALL be accepted at the next rising edge.

Verification
REQ-032 AND model, exp_tt=4'b1000, SETTLE_CYCLES=2, start pulse -> done 16 edges after the start edge, pass=1, fail_mask=4'b0000, busy low the cycle after done.
REQ-033 gate_out stuck at 0, exp_tt=4'b1000 -> pass=0, fail_mask=4'b1000.
REQ-034 OR model, exp_tt=4'b1000 -> fail_mask=4'b0110, pass=0; gate_a/gate_b trace 00,01,10,11 with each vector held 4 cycles.
REQ-035 abort at edge 5 after start -> busy=0, gate_a=gate_b=0 next cycle, and no done; a restart with the AND model then gives pass=1.
REQ-036 rst_n pulsed low mid-SETTLE -> all outputs 0 asynchronously, and no done pulse.
REQ-037 SETTLE_CYCLES=0, start re-pulsed while busy, exp_tt flipped mid-run -> done at edge 8, result computed from the originally latched exp_tt.

Source files
------------

// File: rtl/gate_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gate_test_sequencer
// Purpose  : Walks a 2-input gate through vectors 00,01,10,11 and compares
//            each settled output against a latched expected truth table.
// Revision : 1.0  initial release
// ============================================================================
module gate_test_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] exp_tt,
  input  logic       gate_out,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] c_settle_load = 8'(SETTLE_CYCLES);

  state_t     r_state,      w_state;
  logic [1:0] r_vec_idx,    w_vec_idx;
  logic [7:0] r_settle_cnt, w_settle_cnt;
  logic [3:0] r_exp_tt,     w_exp_tt;
  logic       r_gate_a,     w_gate_a;
  logic       r_gate_b,     w_gate_b;
  logic       r_pass,       w_pass;
  logic [3:0] r_fail_mask,  w_fail_mask;

  logic [1:0] w_vec_inc;
  logic [3:0] w_vec_bit;
  logic       w_mismatch;
  logic [3:0] w_mask_upd;

  assign w_vec_inc  = r_vec_idx + 2'd1;
  assign w_vec_bit  = 4'b0001 << r_vec_idx;
  assign w_mismatch = (gate_out != r_exp_tt[r_vec_idx]);
  // Mask including the vector being sampled this cycle, so DONE sees the final result
  assign w_mask_upd = w_mismatch ? (r_fail_mask | w_vec_bit) : r_fail_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_vec_idx    <= 2'd0;
      r_settle_cnt <= 8'd0;
      r_exp_tt     <= 4'd0;
      r_gate_a     <= 1'b0;
      r_gate_b     <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_mask  <= 4'd0;
    end else begin
      r_state      <= w_state;
      r_vec_idx    <= w_vec_idx;
      r_settle_cnt <= w_settle_cnt;
      r_exp_tt     <= w_exp_tt;
      r_gate_a     <= w_gate_a;
      r_gate_b     <= w_gate_b;
      r_pass       <= w_pass;
      r_fail_mask  <= w_fail_mask;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_vec_idx    = r_vec_idx;
    w_settle_cnt = r_settle_cnt;
    w_exp_tt     = r_exp_tt;
    w_gate_a     = r_gate_a;
    w_gate_b     = r_gate_b;
    w_pass       = r_pass;
    w_fail_mask  = r_fail_mask;

    if (abort) begin
      // Abort wins everywhere, including over a simultaneous start in IDLE
      w_state      = ST_IDLE;
      w_vec_idx    = 2'd0;
      w_settle_cnt = 8'd0;
      w_gate_a     = 1'b0;
      w_gate_b     = 1'b0;
      w_pass       = 1'b0;
      w_fail_mask  = 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state      = ST_SETTLE;
            w_exp_tt     = exp_tt;
            w_pass       = 1'b0;
            w_fail_mask  = 4'd0;
            w_vec_idx    = 2'd0;
            w_gate_a     = 1'b0;
            w_gate_b     = 1'b0;
            w_settle_cnt = c_settle_load;
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt == 8'd0) begin
            w_state = ST_SAMPLE;
          end else begin
            w_settle_cnt = r_settle_cnt - 8'd1;
          end
        end
        ST_SAMPLE: begin
          w_fail_mask = w_mask_upd;
          if (r_vec_idx == 2'd3) begin
            w_state  = ST_DONE;
            w_pass   = (w_mask_upd == 4'd0);
            w_gate_a = 1'b0;
            w_gate_b = 1'b0;
          end else begin
            w_state      = ST_SETTLE;
            w_vec_idx    = w_vec_inc;
            w_gate_a     = w_vec_inc[1];
            w_gate_b     = w_vec_inc[0];
            w_settle_cnt = c_settle_load;
          end
        end
        ST_DONE: begin
          w_state = ST_IDLE;
        end
        default: begin
          w_state = ST_IDLE;
        end
      endcase
    end
  end

  assign gate_a    = r_gate_a;
  assign gate_b    = r_gate_b;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign pass      = r_pass;
  assign fail_mask = r_fail_mask;

endmodule
`default_nettype wire

// File: tb/tb_gate_test_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gate_test_sequencer
// Purpose  : Directed self-checking bench for gate_test_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_gate_test_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, abort0, out0, a0, b0, busy0, done0, pass0;
  logic [3:0] exp0, fm0;
  logic       start1, abort1, out1, a1, b1, busy1, done1, pass1;
  logic [3:0] exp1, fm1;

  int mode0;  // 0 = AND gate, 1 = OR gate, 2 = output stuck at 0
  assign out0 = (mode0 == 0) ? (a0 & b0) : (mode0 == 1) ? (a0 | b0) : 1'b0;
  assign out1 = a1 & b1;

  gate_test_sequencer #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .exp_tt(exp0),
    .gate_out(out0), .gate_a(a0), .gate_b(b0), .busy(busy0), .done(done0),
    .pass(pass0), .fail_mask(fm0)
  );

  gate_test_sequencer #(.SETTLE_CYCLES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .exp_tt(exp1),
    .gate_out(out1), .gate_a(a1), .gate_b(b1), .busy(busy1), .done(done1),
    .pass(pass1), .fail_mask(fm1)
  );

  int         errors = 0;
  int         checks = 0;
  int         n;
  bit         seen;
  logic [1:0] trace [0:31];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start on DUT0, then count edges until done, recording the gate inputs
  task automatic run0(input logic [3:0] tt, input int md, output int cnt);
    mode0 = md;
    exp0  = tt;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    cnt = 0;
    trace[0] = {a0, b0};
    while (done0 !== 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt < 32) trace[cnt] = {a0, b0};
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    start0 = 0; abort0 = 0; exp0 = 4'd0; mode0 = 0;
    start1 = 0; abort1 = 0; exp1 = 4'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy",  32'(busy0), 32'd0);
    chk("rst_done",  32'(done0), 32'd0);
    chk("rst_gates", 32'({a0, b0}), 32'd0);
    chk("rst_pass",  32'(pass0), 32'd0);
    chk("rst_mask",  32'(fm0), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // AND gate, expected AND truth table
    run0(4'b1000, 0, n);
    chk("and_gates_first", 32'(trace[0]), 32'd0);
    chk("and_latency", n, 32'd16);
    @(posedge clk); #1;
    chk("and_busy_after", 32'(busy0), 32'd0);
    chk("and_done_pulse", 32'(done0), 32'd0);
    chk("and_pass", 32'(pass0), 32'd1);
    chk("and_mask", 32'(fm0), 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("idle_hold_pass", 32'(pass0), 32'd1);

    // Output stuck at 0
    run0(4'b1000, 2, n);
    chk("stuck_latency", n, 32'd16);
    @(posedge clk); #1;
    chk("stuck_pass", 32'(pass0), 32'd0);
    chk("stuck_mask", 32'(fm0), 32'b1000);

    // OR gate against AND expectations, plus vector trace
    run0(4'b1000, 1, n);
    chk("or_latency", n, 32'd16);
    for (int k = 0; k < 16; k++) chk($sformatf("or_trace_%0d", k), 32'(trace[k]), 32'(k / 4));
    chk("or_trace_done", 32'(trace[16]), 32'd0);
    @(posedge clk); #1;
    chk("or_pass", 32'(pass0), 32'd0);
    chk("or_mask", 32'(fm0), 32'b0110);

    // Abort at edge 5 after start, after vector 0 already failed
    mode0 = 2; exp0 = 4'b0001;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("abort_pre_mask", 32'(fm0), 32'b0001);
    chk("abort_pre_busy", 32'(busy0), 32'd1);
    @(negedge clk); abort0 = 1'b1;
    @(posedge clk); #1; abort0 = 1'b0;
    chk("abort_busy",  32'(busy0), 32'd0);
    chk("abort_gates", 32'({a0, b0}), 32'd0);
    chk("abort_mask",  32'(fm0), 32'd0);
    chk("abort_pass",  32'(pass0), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done0 === 1'b1) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run0(4'b1000, 0, n);
    chk("restart_latency", n, 32'd16);
    @(posedge clk); #1;
    chk("restart_pass", 32'(pass0), 32'd1);

    // start and abort together in IDLE
    @(negedge clk); start0 = 1'b1; abort0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0; abort0 = 1'b0;
    chk("start_abort_busy", 32'(busy0), 32'd0);
    @(posedge clk); #1;
    chk("start_abort_busy2", 32'(busy0), 32'd0);

    // Reset mid-SETTLE of vector 1
    mode0 = 2; exp0 = 4'b0001;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("midrst_pre_gates", 32'({a0, b0}), 32'b01);
    chk("midrst_pre_mask",  32'(fm0), 32'b0001);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy",  32'(busy0), 32'd0);
    chk("midrst_gates", 32'({a0, b0}), 32'd0);
    chk("midrst_done",  32'(done0), 32'd0);
    chk("midrst_mask",  32'(fm0), 32'd0);
    chk("midrst_pass",  32'(pass0), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done0 === 1'b1) seen = 1'b1;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    // First start right after reset release is accepted at the next edge
    @(negedge clk); rst_n = 1'b1; mode0 = 0; exp0 = 4'b1000; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    chk("post_rst_accept", 32'(busy0), 32'd1);
    n = 0;
    while (done0 !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("post_rst_latency", n, 32'd16);
    @(posedge clk); #1;
    chk("post_rst_pass", 32'(pass0), 32'd1);

    // SETTLE_CYCLES=0: restart ignored while busy, exp_tt change ignored
    @(negedge clk); exp1 = 4'b1000; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 100) begin
      if (n == 2) begin
        start1 = 1'b1;
        exp1   = 4'b0111;
      end else begin
        start1 = 1'b0;
      end
      @(posedge clk); #1; n++;
    end
    start1 = 1'b0;
    chk("s0_latency", n, 32'd8);
    @(posedge clk); #1;
    chk("s0_busy_after", 32'(busy1), 32'd0);
    chk("s0_pass", 32'(pass1), 32'd1);
    chk("s0_mask", 32'(fm1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
